// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, pointer-width helper and typedefs for fifo_sync_param
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Pointers carry one extra wrap bit above the memory index
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PW = ptr_width(DEF_DEPTH);

  typedef logic [DEF_PW-1:0] ptr_t;
  typedef logic [DEF_PW-1:0] count_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - register-array memory, synchronous write port, asynchronous read port
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with count, thresholds and sticky errors
// FIFO_FWFT_EN selects first-word-fall-through output; default is registered read data.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     FIFO_full,
  output logic                     FIFO_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR  = PW'(AE_LEVEL);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  assign FIFO_empty   = (wr_ptr_q == rd_ptr_q);
  assign FIFO_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read
  assign rd_acc = rd_en && !FIFO_empty;
  assign wr_acc = wr_en && (!FIFO_full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Set wins over clear when an error coincides with clr_err
    ovf_d = (ovf_q && !clr_err) || (wr_en && !wr_acc);
    unf_d = (unf_q && !clr_err) || (rd_en && FIFO_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && !reset),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign data_out = FIFO_empty ? '0 : mem_rdata;
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) begin
      dout_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - randomized bench for fifo_sync_param against a queue reference model
// Honours FIFO_FWFT_EN to match the build of the design.
module tb_fifo_sync_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [WIDTH-1:0]       data_in;
  logic                   wr_en, rd_en, clr_err;
  logic [WIDTH-1:0]       data_out;
  logic                   FIFO_full, FIFO_empty, almost_full, almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf  = 1'b0;
  logic             m_unf  = 1'b0;

  fifo_sync_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .FIFO_full    (FIFO_full),
    .FIFO_empty   (FIFO_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (m_q.size() != 0) ? m_q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic compare_all();
    int n;
    n = m_q.size();
    check_eq("count",        32'(count),   32'(n));
    check_eq("full",         FIFO_full,    n == DEPTH);
    check_eq("empty",        FIFO_empty,   n == 0);
    check_eq("almost_full",  almost_full,  n >= AF);
    check_eq("almost_empty", almost_empty, n <= AE);
    check_eq("overflow",     overflow,     m_ovf);
    check_eq("underflow",    underflow,    m_unf);
    check_eq("data_out",     32'(data_out), 32'(exp_dout()));
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, check 1 ns later
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                      input logic c, input logic rs);
    logic was_empty, was_full, rd_ok, wr_ok;
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d; clr_err = c; reset = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      rd_ok = r && !was_empty;
      wr_ok = w && (!was_full || rd_ok);
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
      m_ovf = (m_ovf && !c) || (w && !wr_ok);
      m_unf = (m_unf && !c) || (r && was_empty);
    end
    #1;
    compare_all();
  endtask

  initial begin
    int wb, rb;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;

    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, '0, 0, 0);
    check_eq("idle_underflow", underflow, 1'b1);
    check_eq("idle_dout", 32'(data_out), 32'h0);
    check_eq("idle_count", 32'(count), 32'h0);

    step(0, 0, '0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, WIDTH'(i), 0, 0);
      check_eq("fill_almost_full", almost_full, i >= 6);
    end
    check_eq("fill_full", FIFO_full, 1'b1);
    step(1, 0, WIDTH'(9), 0, 0);
    check_eq("ninth_overflow", overflow, 1'b1);
    check_eq("ninth_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, '0, 0, 0);
`ifndef FIFO_FWFT_EN
      check_eq("drain_order", 32'(data_out), 32'(i));
`endif
    end
    check_eq("drain_empty", FIFO_empty, 1'b1);

    step(0, 0, '0, 1, 0);
    for (int i = 1; i <= 8; i++) step(1, 0, WIDTH'(i), 0, 0);
    for (int i = 9; i <= 18; i++) begin
      step(1, 1, WIDTH'(i), 0, 0);
      check_eq("stream_count", 32'(count), 32'd8);
`ifndef FIFO_FWFT_EN
      check_eq("stream_order", 32'(data_out), 32'(i - 8));
`endif
    end
    check_eq("stream_no_overflow", overflow, 1'b0);

    for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    step(1, 1, 16'hAAAA, 0, 0);
    check_eq("simul_count", 32'(count), 32'd1);
    check_eq("simul_underflow", underflow, 1'b1);
    step(0, 0, '0, 1, 0);
    check_eq("clr_underflow", underflow, 1'b0);
`ifdef FIFO_FWFT_EN
    check_eq("fwft_head", 32'(data_out), 32'hAAAA);
`endif
    step(0, 1, '0, 0, 0);
`ifndef FIFO_FWFT_EN
    check_eq("simul_read", 32'(data_out), 32'hAAAA);
`endif

    for (int i = 0; i < 5; i++) step(1, 0, WIDTH'($urandom), 0, 0);
    step(1, 1, 16'hBEEF, 0, 1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", FIFO_empty, 1'b1);
    check_eq("rst_errors", 32'({overflow, underflow}), 32'd0);
    step(1, 0, 16'h1234, 0, 0);
`ifdef FIFO_FWFT_EN
    check_eq("fwft_no_rd", 32'(data_out), 32'h1234);
`endif
    step(0, 1, '0, 0, 0);
`ifdef FIFO_FWFT_EN
    check_eq("fwft_popped", 32'(data_out), 32'h0);
`else
    check_eq("post_rst_read", 32'(data_out), 32'h1234);
`endif

    // Bias shifts between phases so the queue spends time near both full and empty
    for (int ph = 0; ph < 8; ph++) begin
      wb = (ph % 2 == 0) ? 75 : 30;
      rb = (ph % 2 == 0) ? 35 : 70;
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, WIDTH'($urandom),
             $urandom_range(0, 31) == 0, $urandom_range(0, 299) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
